// File: rtl/servant_uart_ctrl.sv
// Wishbone-side control for a byte UART transmitter: TX FIFO, status/control
// registers and a start/wait handshake with the transmitter.
module servant_uart_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter string       RESET_STRATEGY = ""
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx_active,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          en, ovf;
  logic          req, full, empty, pop, wr_tx, push, ovf_set, ovf_clr, wr_ctrl;
  logic [31:0]   rdata;
  logic          unused_dat;

  assign unused_dat = ^i_wb_dat[31:8];

  assign req     = i_wb_cyc & ~o_wb_ack;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = (state == IDLE) & en & ~empty;
  assign wr_tx   = req & i_wb_we & (i_wb_adr == 2'd0);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push    = wr_tx & (~full | pop);
  assign ovf_set = wr_tx & full & ~pop;
  assign wr_ctrl = req & i_wb_we & (i_wb_adr == 2'd2);
  assign ovf_clr = wr_ctrl & i_wb_dat[1];

  always_comb begin
    rdata = '0;
    case (i_wb_adr)
      2'd1: begin
        rdata[0]    = empty;
        rdata[1]    = full;
        rdata[2]    = (state != IDLE);
        rdata[3]    = ovf;
        rdata[11:8] = 4'(count);
      end
      2'd2:    rdata[0] = en;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (push) mem[wr_ptr] <= i_wb_dat[7:0];
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      en          <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_data   <= '0;
      o_wb_rdt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (wr_ctrl) en <= i_wb_dat[0];
      if (req) o_wb_rdt <= rdata;

      o_tx_active <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          state       <= START;
          o_tx_active <= 1'b1;
          o_tx_data   <= mem[rd_ptr];
        end
        START:   state <= WAIT;
        WAIT:    if (i_tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  if (RESET_STRATEGY != "NONE") begin : g_ack_rst
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) o_wb_ack <= 1'b0;
      else          o_wb_ack <= i_wb_cyc & ~o_wb_ack;
    end
  end else begin : g_ack_norst
    always_ff @(posedge i_wb_clk) begin
      o_wb_ack <= i_wb_cyc & ~o_wb_ack;
    end
  end

endmodule

// File: tb/tb_servant_uart_ctrl.sv
// Scoreboard bench for servant_uart_ctrl: bus reads and transmitted bytes are
// queued at issue time and checked by a monitor when the DUT presents them.
module tb_servant_uart_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic        we, cyc;
  logic [31:0] rdt;
  logic        ack, tx_active, tx_done;
  logic [7:0]  tx_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct packed { logic rd; logic [31:0] exp; } bus_t;
  bus_t       bus_q[$];
  logic [7:0] tx_q[$];

  bit auto_done  = 1'b0;
  bit rand_delay = 1'b0;

  always #5 clk = ~clk;

  servant_uart_ctrl #(.DEPTH(8), .RESET_STRATEGY("")) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack),
    .o_tx_active(tx_active), .o_tx_data(tx_data), .i_tx_done(tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or starts a byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack) begin
        if (bus_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ack_unexpected: got ack=1 expected no pending transfer at %0t", $time);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          if (e.rd) check("rdt", rdt, e.exp);
        end
      end
      if (tx_active) begin
        if (tx_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got byte %h expected none at %0t", tx_data, $time);
        end else begin
          logic [7:0] b;
          b = tx_q.pop_front();
          check("tx_data", {24'b0, tx_data}, {24'b0, b});
        end
      end
    end
  end

  // Transmitter model: tx_done arrives in the d-th WAIT cycle.
  always @(negedge clk) begin : responder
    int unsigned d;
    if (auto_done && tx_active && !rst) begin
      d = rand_delay ? $urandom_range(10, 1) : 1;
      repeat (d) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the ack edge.
  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] exp_rdt);
    bus_t e;
    e.rd = ~w; e.exp = exp_rdt;
    bus_q.push_back(e);
    adr = a; we = w; dat = d; cyc = 1'b1;
    @(posedge clk); #1;
    check("ack_high", ack, 1);
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_low", ack, 0);
  endtask

  task automatic drain();
    int unsigned i = 0;
    while (tx_q.size() != 0 && i < 2000) begin
      @(posedge clk); i++;
    end
    repeat (15) @(posedge clk);
    #1;
    check("drain", tx_q.size(), 0);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat = '0; we = 1'b0; cyc = 1'b0; tx_done = 1'b0;
    #1;
    check("rst_tx_active", tx_active, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rdt", rdt, 0);
    check("rst_ack", ack, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Register map basics
    bus(2'd1, 1'b0, 0, 32'h0000_0001);
    bus(2'd2, 1'b0, 0, 32'h0000_0001);
    bus(2'd3, 1'b1, 32'hFFFF_FFFF, 0);
    bus(2'd3, 1'b0, 0, 32'h0);
    bus(2'd0, 1'b0, 0, 32'h0);
    bus(2'd1, 1'b0, 0, 32'h0000_0001);

    // Single write with exact start-pulse timing and BUSY
    begin
      bus_t e;
      e.rd = 1'b0; e.exp = '0;
      bus_q.push_back(e);
      tx_q.push_back(8'h41);
      adr = 2'd0; we = 1'b1; dat = 32'h41; cyc = 1'b1;
      @(posedge clk); #1;
      check("single_ack", ack, 1);
      check("single_no_start_yet", tx_active, 0);
      cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("single_start", tx_active, 1);
      check("single_data", tx_data, 32'h41);
    end
    bus(2'd1, 1'b0, 0, 32'h0000_0005);
    bus(2'd1, 1'b0, 0, 32'h0000_0005);
    check("single_hold", tx_data, 32'h41);
    pulse_done();
    bus(2'd1, 1'b0, 0, 32'h0000_0001);

    // Overflow with EN=0, then drain in order
    auto_done = 1'b1;
    bus(2'd2, 1'b1, 32'h0, 0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'(i));
      bus(2'd0, 1'b1, 32'(i), 0);
    end
    bus(2'd1, 1'b0, 0, 32'h0000_080A);
    bus(2'd2, 1'b1, 32'h1, 0);
    drain();
    bus(2'd1, 1'b0, 0, 32'h0000_0009);

    // OVF clear via CTRL=3
    bus(2'd2, 1'b1, 32'h3, 0);
    bus(2'd1, 1'b0, 0, 32'h0000_0001);
    bus(2'd2, 1'b0, 0, 32'h0000_0001);

    // Full FIFO write coinciding with the IDLE->START pop
    auto_done = 1'b0;
    bus(2'd2, 1'b1, 32'h0, 0);
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'(8'h10 + i));
      bus(2'd0, 1'b1, 32'(8'h10 + i), 0);
    end
    bus(2'd2, 1'b1, 32'h1, 0);
    tx_q.push_back(8'h18);
    bus(2'd0, 1'b1, 32'h18, 0);
    bus(2'd1, 1'b0, 0, 32'h0000_0806);
    pulse_done();
    begin
      bus_t e;
      e.rd = 1'b0; e.exp = '0;
      bus_q.push_back(e);
      tx_q.push_back(8'h19);
      adr = 2'd0; we = 1'b1; dat = 32'h19; cyc = 1'b1;
      @(posedge clk); #1;
      check("fullpop_ack", ack, 1);
      check("fullpop_start", tx_active, 1);
      cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
    end
    bus(2'd1, 1'b0, 0, 32'h0000_0806);
    pulse_done();
    auto_done = 1'b1;
    drain();
    bus(2'd1, 1'b0, 0, 32'h0000_0001);

    // Asynchronous reset while waiting for tx_done
    auto_done = 1'b0;
    tx_q.push_back(8'h55);
    bus(2'd0, 1'b1, 32'h55, 0);
    @(posedge clk); #1;
    check("pre_rst_data", tx_data, 32'h55);
    #1 rst = 1'b1;
    #1;
    check("arst_tx_active", tx_active, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_rdt", rdt, 0);
    check("arst_ack", ack, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    pulse_done();
    repeat (3) @(posedge clk);
    #1;
    bus(2'd1, 1'b0, 0, 32'h0000_0001);
    bus(2'd2, 1'b0, 0, 32'h0000_0001);

    // Pointer wrap with random transmitter latency
    auto_done = 1'b1; rand_delay = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int unsigned g = 0;
      logic [7:0] b;
      while (tx_q.size() >= 8 && g < 500) begin
        @(posedge clk); #1; g++;
      end
      b = 8'(8'h30 + i * 5);
      tx_q.push_back(b);
      bus(2'd0, 1'b1, {24'b0, b}, 0);
    end
    drain();
    bus(2'd1, 1'b0, 0, 32'h0000_0001);

    repeat (4) @(posedge clk);
    #1;
    check("bus_q_empty", bus_q.size(), 0);
    check("tx_q_empty", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
